// File: rtl/ifu_flush_ctrl_pkg.sv
// Shared sizes, reset PC and FSM state encoding for the fetch flush/halt controller.
package ifu_flush_ctrl_pkg;

    localparam int          IFU_PC_SIZE    = 32;
    localparam int          IFU_INSTR_SIZE = 32;
    localparam int          IFU_MAX_OUTSTD = 2;
    localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;

    typedef enum logic [1:0] {
        IFU_ST_RUN       = 2'd0,
        IFU_ST_WFI_DRAIN = 2'd1,
        IFU_ST_HALT      = 2'd2
    } ifu_state_e;

    // Counters must be able to hold MAX_OUTSTD itself, hence the extra bit.
    function automatic int ifu_cnt_width(input int max_outstd);
        return $clog2(max_outstd) + 1;
    endfunction

endpackage

// File: rtl/ifu_pc_fifo.sv
// Small synchronous FIFO holding the PC of every in-flight fetch; head is read combinationally.
module ifu_pc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;

    // Explicit wrap keeps DEPTH==1 correct where the pointer has a spare bit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head = mem[rd_ptr_reg];

endmodule

// File: rtl/ifu_flush_ctrl.sv
// Fetch request generator that follows commit redirects, drops stale responses and quiesces for WFI.
module ifu_flush_ctrl
    import ifu_flush_ctrl_pkg::*;
#(
    parameter int                  PC_SIZE    = IFU_PC_SIZE,
    parameter int                  INSTR_SIZE = IFU_INSTR_SIZE,
    parameter int                  MAX_OUTSTD = IFU_MAX_OUTSTD,
    parameter logic [PC_SIZE-1:0]  RESET_PC   = PC_SIZE'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i_req,
    input  logic [PC_SIZE-1:0]    flush_i_pc,
    output logic                  flush_o_ack,
    input  logic                  core_wfi_i,
    input  logic                  irq_wake_i,
    output logic                  wfi_halt_ack_o,
    output logic                  fch_o_req_valid,
    input  logic                  fch_i_req_ready,
    output logic [PC_SIZE-1:0]    fch_o_req_pc,
    input  logic                  fch_i_rsp_valid,
    input  logic [INSTR_SIZE-1:0] fch_i_rsp_instr,
    input  logic                  fch_i_rsp_err,
    output logic                  fch_o_rsp_ready,
    output logic                  ifu_o_valid,
    output logic [PC_SIZE-1:0]    ifu_o_pc,
    output logic [INSTR_SIZE-1:0] ifu_o_instr,
    output logic                  ifu_o_buserr
);

    localparam int CNT_W = ifu_cnt_width(MAX_OUTSTD);

    ifu_state_e         state_reg;
    logic [PC_SIZE-1:0] pc_reg;
    logic [CNT_W-1:0]   outstd_reg;
    logic [CNT_W-1:0]   kill_reg;
    logic               flush_ack_reg;
    logic               halt_ack_reg;
    logic               wake_pend_reg;

    logic [CNT_W-1:0]   outstd_next;
    logic               req_valid;
    logic               req_fire;
    logic               rsp_drop;
    logic               drained;
    logic               wake_req;
    logic [PC_SIZE-1:0] head_pc;

    assign req_valid = ~rst & (state_reg == IFU_ST_RUN) & ~flush_i_req
                     & (outstd_reg < CNT_W'(MAX_OUTSTD));
    assign req_fire  = req_valid & fch_i_req_ready;
    assign rsp_drop  = fch_i_rsp_valid & ((kill_reg != '0) | flush_i_req);
    assign wake_req  = irq_wake_i & ~core_wfi_i;

    always_comb begin
        outstd_next = outstd_reg;
        if (req_fire && !fch_i_rsp_valid) begin
            outstd_next = outstd_reg + CNT_W'(1);
        end else if (!req_fire && fch_i_rsp_valid) begin
            outstd_next = outstd_reg - CNT_W'(1);
        end
    end

    // Includes this cycle's response, so the halt ack rises the cycle after the last one.
    assign drained = (outstd_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IFU_ST_RUN;
            pc_reg        <= RESET_PC;
            outstd_reg    <= '0;
            kill_reg      <= '0;
            flush_ack_reg <= 1'b0;
            halt_ack_reg  <= 1'b0;
            wake_pend_reg <= 1'b0;
        end else begin
            outstd_reg    <= outstd_next;
            flush_ack_reg <= flush_i_req;
            if (flush_i_req) begin
                // Everything still on the bus after this cycle belongs to the old path.
                pc_reg        <= flush_i_pc;
                kill_reg      <= outstd_next;
                state_reg     <= IFU_ST_RUN;
                halt_ack_reg  <= 1'b0;
                wake_pend_reg <= 1'b0;
            end else begin
                if (req_fire) begin
                    pc_reg <= pc_reg + PC_SIZE'(4);
                end
                if (fch_i_rsp_valid && kill_reg != '0) begin
                    kill_reg <= kill_reg - CNT_W'(1);
                end
                case (state_reg)
                    IFU_ST_RUN: begin
                        if (core_wfi_i) begin
                            state_reg <= IFU_ST_WFI_DRAIN;
                        end
                    end
                    IFU_ST_WFI_DRAIN: begin
                        if (drained) begin
                            wake_pend_reg <= 1'b0;
                            if (wake_pend_reg || wake_req) begin
                                state_reg <= IFU_ST_RUN;
                            end else begin
                                state_reg    <= IFU_ST_HALT;
                                halt_ack_reg <= 1'b1;
                            end
                        end else if (wake_req) begin
                            wake_pend_reg <= 1'b1;
                        end
                    end
                    IFU_ST_HALT: begin
                        if (wake_req) begin
                            state_reg    <= IFU_ST_RUN;
                            halt_ack_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg    <= IFU_ST_RUN;
                        halt_ack_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    ifu_pc_fifo #(
        .DEPTH (MAX_OUTSTD),
        .WIDTH (PC_SIZE)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_reg),
        .pop       (fch_i_rsp_valid),
        .head      (head_pc)
    );

    assign fch_o_req_valid = req_valid;
    assign fch_o_req_pc    = pc_reg;
    assign fch_o_rsp_ready = 1'b1;
    assign ifu_o_valid     = fch_i_rsp_valid & ~rsp_drop & ~rst;
    assign ifu_o_pc        = head_pc;
    assign ifu_o_instr     = fch_i_rsp_instr;
    assign ifu_o_buserr    = fch_i_rsp_err;
    assign flush_o_ack     = flush_ack_reg;
    assign wfi_halt_ack_o  = halt_ack_reg;

    a_rsp_needs_outstd: assert property (@(posedge clk) disable iff (rst)
        fch_i_rsp_valid |-> (outstd_reg != '0));
    a_outstd_bound: assert property (@(posedge clk) disable iff (rst)
        outstd_reg <= CNT_W'(MAX_OUTSTD));
    a_kill_bound: assert property (@(posedge clk) disable iff (rst)
        kill_reg <= outstd_reg);

endmodule

// File: tb/tb_ifu_flush_ctrl.sv
// Bench for ifu_flush_ctrl: directed vector table, wrap/reset sequence, then random traffic vs a queue model.
module tb_ifu_flush_ctrl;

    localparam int MAX = 2;

    typedef struct {
        logic        flush;
        logic [31:0] fpc;
        logic        wfi;
        logic        wake;
        logic        rdy;
        logic        rv;
        logic        e_rv;
        logic [31:0] e_pc;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic        e_fack;
        logic        e_hack;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        stale;
    } inflight_t;

    typedef enum int {M_RUN, M_DRAIN, M_HALT} mode_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i_req = 1'b0;
    logic [31:0] flush_i_pc = '0;
    logic        flush_o_ack;
    logic        core_wfi_i = 1'b0;
    logic        irq_wake_i = 1'b0;
    logic        wfi_halt_ack_o;
    logic        fch_o_req_valid;
    logic        fch_i_req_ready = 1'b0;
    logic [31:0] fch_o_req_pc;
    logic        fch_i_rsp_valid = 1'b0;
    logic [31:0] fch_i_rsp_instr = '0;
    logic        fch_i_rsp_err = 1'b0;
    logic        fch_o_rsp_ready;
    logic        ifu_o_valid;
    logic [31:0] ifu_o_pc;
    logic [31:0] ifu_o_instr;
    logic        ifu_o_buserr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_flush_ctrl #(
        .PC_SIZE    (32),
        .INSTR_SIZE (32),
        .MAX_OUTSTD (MAX),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i_req     (flush_i_req),
        .flush_i_pc      (flush_i_pc),
        .flush_o_ack     (flush_o_ack),
        .core_wfi_i      (core_wfi_i),
        .irq_wake_i      (irq_wake_i),
        .wfi_halt_ack_o  (wfi_halt_ack_o),
        .fch_o_req_valid (fch_o_req_valid),
        .fch_i_req_ready (fch_i_req_ready),
        .fch_o_req_pc    (fch_o_req_pc),
        .fch_i_rsp_valid (fch_i_rsp_valid),
        .fch_i_rsp_instr (fch_i_rsp_instr),
        .fch_i_rsp_err   (fch_i_rsp_err),
        .fch_o_rsp_ready (fch_o_rsp_ready),
        .ifu_o_valid     (ifu_o_valid),
        .ifu_o_pc        (ifu_o_pc),
        .ifu_o_instr     (ifu_o_instr),
        .ifu_o_buserr    (ifu_o_buserr)
    );

    function automatic vec_t mk(input logic f, input logic [31:0] fpc, input logic w, input logic k,
                                input logic r, input logic rv, input logic erv, input logic [31:0] epc,
                                input logic eiv, input logic [31:0] eipc, input logic efa, input logic eha);
        vec_t v;
        v.flush = f;   v.fpc = fpc;   v.wfi = w;    v.wake = k;
        v.rdy = r;     v.rv = rv;     v.e_rv = erv; v.e_pc = epc;
        v.e_iv = eiv;  v.e_ipc = eipc; v.e_fack = efa; v.e_hack = eha;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input string tag);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s]: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, check mid-cycle, then advance.
    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] ins;
        logic        err;
        ins = $urandom;
        err = ($urandom_range(0, 7) == 0);
        flush_i_req     = v.flush;
        flush_i_pc      = v.fpc;
        core_wfi_i      = v.wfi;
        irq_wake_i      = v.wake;
        fch_i_req_ready = v.rdy;
        fch_i_rsp_valid = v.rv;
        fch_i_rsp_instr = v.rv ? ins : 32'h0;
        fch_i_rsp_err   = v.rv & err;
        #4;
        chk("req_valid", 32'(fch_o_req_valid), 32'(v.e_rv), tag);
        if (v.e_rv) chk("req_pc", fch_o_req_pc, v.e_pc, tag);
        chk("ifu_valid", 32'(ifu_o_valid), 32'(v.e_iv), tag);
        if (v.e_iv) begin
            chk("ifu_pc", ifu_o_pc, v.e_ipc, tag);
            chk("ifu_instr", ifu_o_instr, ins, tag);
            chk("ifu_buserr", 32'(ifu_o_buserr), 32'(err), tag);
        end
        chk("flush_ack", 32'(flush_o_ack), 32'(v.e_fack), tag);
        chk("halt_ack", 32'(wfi_halt_ack_o), 32'(v.e_hack), tag);
        chk("rsp_ready", 32'(fch_o_rsp_ready), 32'h1, tag);
        $display("%s: flush=%0b wfi=%0b wake=%0b rdy=%0b rsp=%0b | req_v=%0b pc=%h ifu_v=%0b ifu_pc=%h fack=%0b hack=%0b",
                 tag, v.flush, v.wfi, v.wake, v.rdy, v.rv, fch_o_req_valid, fch_o_req_pc,
                 ifu_o_valid, ifu_o_pc, flush_o_ack, wfi_halt_ack_o);
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[$];
    vec_t        hand[$];
    vec_t        zero_v;
    vec_t        v;
    inflight_t   q[$];
    inflight_t   e;
    mode_t       m_mode;
    logic [31:0] m_pc;
    logic        m_fack;
    logic        m_wake;

    initial begin
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Sequential fetch, flush with two in flight, ready stall, full stall, WFI drain/wake, flush in HALT.
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h8000_0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'h8000_0004, 1, 32'h8000_0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'h8000_0008, 1, 32'h8000_0004, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h8000_000C, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h100, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h100, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h104, 1, 32'h100, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h104, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h108, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 32'h104, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h10C, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 32'h108, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 32'h10C, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h110, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h114, 1, 32'h110, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'h114, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h200, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h200, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h204, 1, 32'h200, 0, 0));

        // PC wrap, then drain interrupted by reset.
        hand.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        hand.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0));
        hand.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h0000_0000, 0, 0, 0, 0));
        hand.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        hand.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_vec(zero_v, "reset");
        chk("reset_pc", fch_o_req_pc, 32'h8000_0000, "reset");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < hand.size(); i++) run_vec(hand[i], $sformatf("wrap%0d", i));

        rst = 1'b1;
        run_vec(zero_v, "mid_drain_rst");
        rst = 1'b0;
        run_vec(mk(0, 0, 0, 0, 1, 0, 1, 32'h8000_0000, 0, 0, 0, 0), "post_rst0");
        run_vec(mk(0, 0, 0, 0, 1, 0, 1, 32'h8000_0004, 0, 0, 0, 0), "post_rst1");
        run_vec(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "post_rst2");
        run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h8000_0000, 0, 0), "post_rst3");
        run_vec(mk(0, 0, 0, 0, 0, 1, 1, 32'h8000_0008, 1, 32'h8000_0004, 0, 0), "post_rst4");

        // Random traffic; the model tags in-flight fetches stale on a redirect.
        rst = 1'b1;
        run_vec(zero_v, "rand_reset");
        rst = 1'b0;
        q.delete();
        m_mode = M_RUN;
        m_pc   = 32'h8000_0000;
        m_fack = 1'b0;
        m_wake = 1'b0;
        for (int c = 0; c < 800; c++) begin
            v = zero_v;
            v.flush = ($urandom_range(0, 15) == 0);
            v.fpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            v.wfi   = ($urandom_range(0, 19) == 0);
            v.wake  = ($urandom_range(0, 7) == 0);
            v.rdy   = ($urandom_range(0, 3) != 0);
            v.rv    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            v.e_fack = m_fack;
            v.e_hack = (m_mode == M_HALT);
            v.e_rv   = (m_mode == M_RUN) && !v.flush && (q.size() < MAX);
            v.e_pc   = m_pc;
            if (v.rv) begin
                e = q.pop_front();
                v.e_iv  = !e.stale && !v.flush;
                v.e_ipc = e.pc;
            end
            if (v.e_rv && v.rdy) begin
                q.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            m_fack = v.flush;
            if (v.flush) begin
                foreach (q[i]) q[i].stale = 1'b1;
                m_pc   = v.fpc;
                m_mode = M_RUN;
                m_wake = 1'b0;
            end else begin
                case (m_mode)
                    M_RUN:   if (v.wfi) m_mode = M_DRAIN;
                    M_DRAIN: begin
                        if (q.size() == 0) begin
                            m_mode = (m_wake || (v.wake && !v.wfi)) ? M_RUN : M_HALT;
                            m_wake = 1'b0;
                        end else if (v.wake && !v.wfi) begin
                            m_wake = 1'b1;
                        end
                    end
                    default: if (v.wake && !v.wfi) m_mode = M_RUN;
                endcase
            end
            run_vec(v, $sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
